cci_mpf_prim_ram_multi_rd: RTL and testbench
============================================

Name: cci_mpf_prim_ram_multi_rd

Overview:
Simple dual-port RAM successor with N replicated read ports, byte-enabled writes, reset-time initialization and a configurable read pipeline. Full-pipeline write-to-read bypass is byte-granular.
One write port feeds N_READ_PORTS identical storage banks, giving every read port an independent address.
Used by MPF tag/state tables that need several lookups per cycle plus a clean state after reset.

Parameters:
- N_ENTRIES, 32, storage depth; AW = $clog2(N_ENTRIES).
- N_DATA_BITS, 64, word width; must be a multiple of 8, otherwise elaboration fails; NB = N_DATA_BITS/8.
- N_READ_PORTS, 2, number of independent read ports (>=1).
- N_OUTPUT_REG_STAGES, 0, extra output register stages; read latency L = 1 + N_OUTPUT_REG_STAGES.
- BYPASS_FULL_PIPELINE, 1, 1 = writes landing while a read is in flight are merged into that read's result; 0 = old-data semantics.
- INIT_VALUE, 0, value written to every entry after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rdy  out  1  high once initialization is complete; stays high until the next reset.
- wen  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  N_DATA_BITS  write data.
- wbyteen  in  NB  per-byte write mask; bit i covers wdata[8i+7:8i].
- rd_en  in  N_READ_PORTS  per-port read request.
- raddr  in  N_READ_PORTS x AW  per-port read address.
- rdata  out  N_READ_PORTS x N_DATA_BITS  per-port read data.
- rvalid  out  N_READ_PORTS  per-port read-data valid.

Behaviour:
- Reset:
  - rdy=0 and rvalid=0 for all ports on the cycle after reset is sampled.
  - The internal init address init_addr returns to 0.
  - rdata is undefined while rvalid=0.
- Init FSM has two states, INIT and READY.
  - INIT: each cycle writes INIT_VALUE, all bytes, at init_addr in every bank, then init_addr+1.
  - When init_addr==N_ENTRIES-1 the FSM moves to READY and rdy rises the following cycle. Init therefore takes exactly N_ENTRIES cycles after reset falls.
  - A non-power-of-2 N_ENTRIES ends at N_ENTRIES-1, not 2^AW-1.
- While rdy=0:
  - wen is ignored; external writes are dropped.
  - rd_en is ignored; no rvalid is ever generated from a request made while rdy=0.
- Writes:
  - A write is committed in the cycle wen=1 is sampled.
  - Only bytes with wbyteen=1 change. wbyteen=0 with wen=1 is a no-op.
  - All banks are updated identically.
- Reads:
  - rd_en[p] sampled at cycle t gives rvalid[p]=1 and rdata[p] at cycle t+L.
  - Ports are fully independent; any address combination is legal, including all ports reading the same entry.
  - Back-to-back reads are allowed every cycle.
- Same-cycle write and read to the same address:
  - BYPASS_FULL_PIPELINE=0: read returns old data.
  - BYPASS_FULL_PIPELINE=1: read returns the new data, merged byte-wise with stored bytes.
- In-flight bypass, BYPASS_FULL_PIPELINE=1:
  - Any write sampled in cycles t..t+L-1 whose waddr matches the in-flight raddr overwrites the enabled bytes of that read's pending result.
  - Later writes take precedence over earlier ones.
  - A write sampled at cycle t+L, the return cycle, is not bypassed.
  - With BYPASS_FULL_PIPELINE=0 there is no bypass at any stage.
- Reset mid-operation: all in-flight rvalid bits are cleared immediately and init restarts from entry 0; no stale rvalid emerges after reset.
- Each bank is implemented as an altsyncram in DUAL_PORT mode with OLD_DATA mixed-port read-during-write; byte enables map to byteena_a.
- Bypass tracking is one pipeline per port holding per stage: raddr, a per-byte hit mask and a bypass data word.
- Throughput is 1 write plus N_READ_PORTS reads per cycle, with no stalls.

Test Plan:
- Init, N_ENTRIES=32, INIT_VALUE=0xA5: deassert reset -> rdy rises exactly 32 cycles later; reads of addresses 0, 17 and 31 return 0xA5 with rvalid at t+L.
- Byte mask, N_DATA_BITS=64, after init to 0: write addr 3 with 0x1122334455667788 and wbyteen=0x0F, then read addr 3 -> 0x0000000055667788.
- Multi-port, N_READ_PORTS=4: addr k holds value k; read addrs 5, 5, 9, 0 in one cycle -> data 5, 5, 9, 0 and all rvalid together at t+L.
- Bypass, L=3, BYPASS=1: read addr 7 (holds 0) at t; writes to 7 at t+1 (0xFF, all bytes), t+2 (0x00AB, wbyteen=0x02), t+3 (0x99) -> rdata at t+3 is 0xABFF.
  - Same sequence with BYPASS=0 -> rdata is 0.
- Same-cycle collision, L=1: write addr 2 = 0x55 while reading addr 2 -> BYPASS=1 returns 0x55, BYPASS=0 returns the old value; the next read returns 0x55 in both cases.
- Reset mid-stream: issue reads every cycle on all ports, assert reset for 1 cycle -> rvalid=0 from the next cycle and stays 0 through the 32-cycle init.
  - Writes issued with rdy=0 do not persist; a post-init read returns INIT_VALUE.

Source files
------------

// File: rtl/cci_mpf_prim_ram_multi_rd_if.sv
// Bundles the write port, per-port read ports and ready flag of the multi-read-port RAM.
interface cci_mpf_prim_ram_multi_rd_if #(
  parameter int unsigned N_ENTRIES    = 32,
  parameter int unsigned N_DATA_BITS  = 64,
  parameter int unsigned N_READ_PORTS = 2
);
  localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int unsigned NB = N_DATA_BITS / 8;

  logic                                      rdy;
  logic                                      wen;
  logic [AW-1:0]                             waddr;
  logic [N_DATA_BITS-1:0]                    wdata;
  logic [NB-1:0]                             wbyteen;
  logic [N_READ_PORTS-1:0]                   rd_en;
  logic [N_READ_PORTS-1:0][AW-1:0]           raddr;
  logic [N_READ_PORTS-1:0][N_DATA_BITS-1:0]  rdata;
  logic [N_READ_PORTS-1:0]                   rvalid;

  modport master (
    input  rdy, rdata, rvalid,
    output wen, waddr, wdata, wbyteen, rd_en, raddr
  );

  modport slave (
    output rdy, rdata, rvalid,
    input  wen, waddr, wdata, wbyteen, rd_en, raddr
  );
endinterface

// File: rtl/cci_mpf_prim_ram_multi_rd.sv
// Byte-enabled RAM with one write port, N replicated read banks, reset-time init and an
// optional read pipeline that merges in-flight writes byte by byte.
module cci_mpf_prim_ram_multi_rd #(
  parameter int unsigned             N_ENTRIES            = 32,
  parameter int unsigned             N_DATA_BITS          = 64,
  parameter int unsigned             N_READ_PORTS         = 2,
  parameter int unsigned             N_OUTPUT_REG_STAGES  = 0,
  parameter int unsigned             BYPASS_FULL_PIPELINE = 1,
  parameter logic [N_DATA_BITS-1:0]  INIT_VALUE           = '0
) (
  input logic                         clk,
  input logic                         reset,
  cci_mpf_prim_ram_multi_rd_if.slave  bus
);
  localparam int unsigned AW  = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int unsigned NB  = N_DATA_BITS / 8;
  localparam int unsigned S   = N_OUTPUT_REG_STAGES;
  localparam bit          BYP = (BYPASS_FULL_PIPELINE != 0);

  if ((N_DATA_BITS % 8) != 0) begin : g_width_check
    $error("N_DATA_BITS must be a multiple of 8");
  end

  function automatic logic [N_DATA_BITS-1:0] f_merge(input logic [N_DATA_BITS-1:0] base,
                                                     input logic [NB-1:0]          be,
                                                     input logic [N_DATA_BITS-1:0] upd);
    logic [N_DATA_BITS-1:0] res;
    res = base;
    for (int b = 0; b < NB; b++) begin
      if (be[b]) res[8*b +: 8] = upd[8*b +: 8];
    end
    return res;
  endfunction

  typedef enum logic {StInit, StReady} state_e;

  state_e        r_state, w_state_next;
  logic [AW-1:0] r_init_addr, w_init_addr_next;

  always_comb begin
    w_state_next     = r_state;
    w_init_addr_next = r_init_addr;
    unique case (r_state)
      StInit: begin
        w_init_addr_next = r_init_addr + 1'b1;
        if (r_init_addr == AW'(N_ENTRIES - 1)) begin
          w_state_next     = StReady;
          w_init_addr_next = '0;
        end
      end
      StReady: begin
        w_state_next = StReady;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StInit;
      r_init_addr <= '0;
    end else begin
      r_state     <= w_state_next;
      r_init_addr <= w_init_addr_next;
    end
  end

  logic                   w_ready, w_ext_wen, w_mem_we;
  logic [AW-1:0]          w_mem_addr;
  logic [N_DATA_BITS-1:0] w_mem_data;
  logic [NB-1:0]          w_mem_be;

  // Init owns the write port until ready; external writes are dropped meanwhile.
  assign w_ready    = (r_state == StReady);
  assign w_ext_wen  = w_ready & bus.wen;
  assign w_mem_we   = ~reset & (~w_ready | bus.wen);
  assign w_mem_addr = w_ready ? bus.waddr   : r_init_addr;
  assign w_mem_data = w_ready ? bus.wdata   : INIT_VALUE;
  assign w_mem_be   = w_ready ? bus.wbyteen : '1;
  assign bus.rdy    = w_ready;

  for (genvar p = 0; p < N_READ_PORTS; p++) begin : g_port
    logic [N_DATA_BITS-1:0] r_mem  [N_ENTRIES];
    logic                   r_vld  [S+1];
    logic [AW-1:0]          r_addr [S+1];
    logic [NB-1:0]          r_hit  [S+1];
    logic [N_DATA_BITS-1:0] r_byp  [S+1];
    logic [N_DATA_BITS-1:0] r_dat  [S+1];

    logic [AW-1:0]          w_cmp_addr [S+1];
    logic [NB-1:0]          w_prev_hit [S+1];
    logic [N_DATA_BITS-1:0] w_prev_byp [S+1];
    logic [NB-1:0]          w_hit      [S+1];
    logic [NB-1:0]          w_hit_next [S+1];
    logic [N_DATA_BITS-1:0] w_byp_next [S+1];

    always_ff @(posedge clk) begin
      if (w_mem_we) begin
        for (int b = 0; b < NB; b++) begin
          if (w_mem_be[b]) r_mem[w_mem_addr][8*b +: 8] <= w_mem_data[8*b +: 8];
        end
      end
    end

    // Stage j sees the write sampled while its read is entering it; later writes win.
    always_comb begin
      w_cmp_addr[0] = bus.raddr[p];
      w_prev_hit[0] = '0;
      w_prev_byp[0] = '0;
      for (int unsigned j = 1; j < S + 1; j++) begin
        w_cmp_addr[j] = r_addr[j-1];
        w_prev_hit[j] = r_hit[j-1];
        w_prev_byp[j] = r_byp[j-1];
      end
      for (int unsigned j = 0; j < S + 1; j++) begin
        w_hit[j]      = (BYP && w_ext_wen && (bus.waddr == w_cmp_addr[j])) ? bus.wbyteen : '0;
        w_hit_next[j] = w_prev_hit[j] | w_hit[j];
        w_byp_next[j] = f_merge(w_prev_byp[j], w_hit[j], bus.wdata);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned j = 0; j < S + 1; j++) r_vld[j] <= 1'b0;
      end else begin
        r_vld[0] <= w_ready & bus.rd_en[p];
        for (int unsigned j = 1; j < S + 1; j++) r_vld[j] <= r_vld[j-1];
      end
    end

    always_ff @(posedge clk) begin
      r_addr[0] <= bus.raddr[p];
      r_dat[0]  <= r_mem[bus.raddr[p]];
      for (int unsigned j = 1; j < S + 1; j++) begin
        r_addr[j] <= r_addr[j-1];
        r_dat[j]  <= r_dat[j-1];
      end
      for (int unsigned j = 0; j < S + 1; j++) begin
        r_hit[j] <= w_hit_next[j];
        r_byp[j] <= w_byp_next[j];
      end
    end

    assign bus.rvalid[p] = r_vld[S];
    assign bus.rdata[p]  = f_merge(r_dat[S], r_hit[S], r_byp[S]);
  end
endmodule

// File: tb/tb_cci_mpf_prim_ram_multi_rd.sv
// Drives two configurations (L=3 with bypass, L=1 without) with identical stimulus and checks
// both against a scoreboard of pending reads that in-flight writes patch.
module tb_cci_mpf_prim_ram_multi_rd;
  localparam int unsigned NE   = 32;
  localparam int unsigned NDB  = 64;
  localparam int unsigned NRP  = 4;
  localparam logic [63:0] INIT = 64'hA5;

  logic clk;
  logic reset;
  logic            wen;
  logic [4:0]      waddr;
  logic [63:0]     wdata;
  logic [7:0]      wbyteen;
  logic [3:0]      rd_en;
  logic [3:0][4:0] raddr;

  cci_mpf_prim_ram_multi_rd_if #(.N_ENTRIES(NE), .N_DATA_BITS(NDB), .N_READ_PORTS(NRP)) if_a ();
  cci_mpf_prim_ram_multi_rd_if #(.N_ENTRIES(NE), .N_DATA_BITS(NDB), .N_READ_PORTS(NRP)) if_b ();

  assign if_a.wen = wen;  assign if_a.waddr = waddr;  assign if_a.wdata = wdata;
  assign if_a.wbyteen = wbyteen;  assign if_a.rd_en = rd_en;  assign if_a.raddr = raddr;
  assign if_b.wen = wen;  assign if_b.waddr = waddr;  assign if_b.wdata = wdata;
  assign if_b.wbyteen = wbyteen;  assign if_b.rd_en = rd_en;  assign if_b.raddr = raddr;

  cci_mpf_prim_ram_multi_rd #(
    .N_ENTRIES(NE), .N_DATA_BITS(NDB), .N_READ_PORTS(NRP), .N_OUTPUT_REG_STAGES(2),
    .BYPASS_FULL_PIPELINE(1), .INIT_VALUE(INIT)
  ) u_dut_a (.clk(clk), .reset(reset), .bus(if_a));

  cci_mpf_prim_ram_multi_rd #(
    .N_ENTRIES(NE), .N_DATA_BITS(NDB), .N_READ_PORTS(NRP), .N_OUTPUT_REG_STAGES(0),
    .BYPASS_FULL_PIPELINE(0), .INIT_VALUE(INIT)
  ) u_dut_b (.clk(clk), .reset(reset), .bus(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    int          p;
    logic [4:0]  addr;
    logic [63:0] data;
    int          due;
  } pend_t;

  pend_t       sb[$];
  logic [63:0] mem_m [2][NE];
  bit          m_rdy [2];
  int          m_cnt [2];
  logic [63:0] last_rd [2][NRP];
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int vld_cnt = 0;

  function automatic int lat(input int d);
    return (d == 0) ? 3 : 1;
  endfunction

  function automatic bit byp(input int d);
    return (d == 0);
  endfunction

  function automatic logic [63:0] mrg(input logic [63:0] base, input logic [7:0] be,
                                      input logic [63:0] upd);
    logic [63:0] r;
    r = base;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = upd[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wen = 1'b0; waddr = '0; wdata = '0; wbyteen = '0; rd_en = '0; raddr = '0;
  endtask

  task automatic clear_last();
    for (int d = 0; d < 2; d++) for (int p = 0; p < NRP; p++) last_rd[d][p] = 'x;
  endtask

  // Model the upcoming edge, take it, then compare both DUTs 1 time unit later.
  task automatic step();
    bit    pre;
    pend_t e;
    logic [3:0]       rv;
    logic [3:0][63:0] rd;
    logic             rdy_g;
    logic [3:0]       exp_v;
    for (int d = 0; d < 2; d++) begin
      pre = m_rdy[d];
      if (reset) begin
        for (int i = sb.size() - 1; i >= 0; i--) if (sb[i].d == d) sb.delete(i);
        m_rdy[d] = 1'b0;
        m_cnt[d] = 0;
      end else if (!pre) begin
        m_cnt[d]++;
        if (m_cnt[d] == NE) begin
          m_rdy[d] = 1'b1;
          for (int k = 0; k < NE; k++) mem_m[d][k] = INIT;
        end
      end else begin
        for (int p = 0; p < NRP; p++) begin
          if (rd_en[p]) begin
            e.d = d; e.p = p; e.addr = raddr[p];
            e.data = mem_m[d][raddr[p]]; e.due = cyc + lat(d);
            sb.push_back(e);
          end
        end
        if (wen) begin
          for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].d == d && byp(d) && sb[i].addr == waddr && sb[i].due >= cyc + 1)
              sb[i].data = mrg(sb[i].data, wbyteen, wdata);
          end
          mem_m[d][waddr] = mrg(mem_m[d][waddr], wbyteen, wdata);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        rv = if_a.rvalid; rd = if_a.rdata; rdy_g = if_a.rdy;
      end else begin
        rv = if_b.rvalid; rd = if_b.rdata; rdy_g = if_b.rdy;
      end
      exp_v = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].d == d && sb[i].due == cyc) begin
          exp_v[sb[i].p] = 1'b1;
          chk($sformatf("rdata dut%0d port%0d addr%0d cyc%0d", d, sb[i].p, sb[i].addr, cyc),
              rd[sb[i].p], sb[i].data);
          sb.delete(i);
        end
      end
      chk($sformatf("rvalid dut%0d cyc%0d", d, cyc), 64'(rv), 64'(exp_v));
      chk($sformatf("rdy dut%0d cyc%0d", d, cyc), 64'(rdy_g), 64'(m_rdy[d]));
      for (int p = 0; p < NRP; p++) if (rv[p]) last_rd[d][p] = rd[p];
      vld_cnt += $countones(rv);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    clear_last();
    step();
    step();
    reset = 1'b0;

    // Stray traffic during init must be ignored.
    wen = 1'b1; waddr = 5'd4; wdata = '1; wbyteen = '1;
    rd_en = 4'hF; raddr[0] = 5'd4; raddr[1] = 5'd1; raddr[2] = 5'd2; raddr[3] = 5'd3;
    repeat (31) step();
    chk("rdy_low_after_31", 64'(if_a.rdy), 64'd0);
    step();
    chk("rdy_high_after_32", 64'(if_a.rdy), 64'd1);
    chk("rdy_high_after_32_b", 64'(if_b.rdy), 64'd1);

    // Init contents, including the address written while not ready.
    idle();
    clear_last();
    rd_en = 4'hF; raddr[0] = 5'd0; raddr[1] = 5'd17; raddr[2] = 5'd31; raddr[3] = 5'd4;
    step();
    idle();
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("init_a0_dut%0d", d), last_rd[d][0], INIT);
      chk($sformatf("init_a17_dut%0d", d), last_rd[d][1], INIT);
      chk($sformatf("init_a31_dut%0d", d), last_rd[d][2], INIT);
      chk($sformatf("init_dropped_wr_dut%0d", d), last_rd[d][3], INIT);
    end

    // addr k holds k
    for (int k = 0; k < 16; k++) begin
      wen = 1'b1; waddr = 5'(k); wdata = 64'(k); wbyteen = '1;
      step();
    end
    idle();
    clear_last();
    rd_en = 4'hF; raddr[0] = 5'd5; raddr[1] = 5'd5; raddr[2] = 5'd9; raddr[3] = 5'd0;
    step();
    idle();
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mport_p0_dut%0d", d), last_rd[d][0], 64'd5);
      chk($sformatf("mport_p1_dut%0d", d), last_rd[d][1], 64'd5);
      chk($sformatf("mport_p2_dut%0d", d), last_rd[d][2], 64'd9);
      chk($sformatf("mport_p3_dut%0d", d), last_rd[d][3], 64'd0);
    end

    // Byte mask
    wen = 1'b1; waddr = 5'd3; wdata = '0; wbyteen = 8'hFF;
    step();
    wdata = 64'h1122334455667788; wbyteen = 8'h0F;
    step();
    idle();
    clear_last();
    rd_en = 4'h1; raddr[0] = 5'd3;
    step();
    idle();
    repeat (3) step();
    for (int d = 0; d < 2; d++)
      chk($sformatf("bytemask_dut%0d", d), last_rd[d][0], 64'h0000000055667788);

    // In-flight bypass: writes on the three cycles after the read
    wen = 1'b1; waddr = 5'd7; wdata = '0; wbyteen = 8'hFF;
    step();
    idle();
    clear_last();
    rd_en = 4'h1; raddr[0] = 5'd7;
    step();
    idle();
    wen = 1'b1; waddr = 5'd7; wdata = 64'hFF; wbyteen = 8'hFF;
    step();
    wdata = 64'hAB00; wbyteen = 8'h02;
    step();
    wdata = 64'h99; wbyteen = 8'hFF;
    step();
    idle();
    repeat (2) step();
    chk("bypass_full_dut0", last_rd[0][0], 64'hABFF);
    chk("bypass_none_dut1", last_rd[1][0], 64'h0);

    // Same-cycle collision on addr 2 (holds 2)
    clear_last();
    wen = 1'b1; waddr = 5'd2; wdata = 64'h55; wbyteen = 8'hFF;
    rd_en = 4'h1; raddr[0] = 5'd2;
    step();
    idle();
    repeat (3) step();
    chk("collide_bypass_dut0", last_rd[0][0], 64'h55);
    chk("collide_old_dut1", last_rd[1][0], 64'h2);
    clear_last();
    rd_en = 4'h1; raddr[0] = 5'd2;
    step();
    idle();
    repeat (3) step();
    chk("collide_after_dut0", last_rd[0][0], 64'h55);
    chk("collide_after_dut1", last_rd[1][0], 64'h55);

    // Dense random traffic on a narrow address range to exercise bypass merging
    repeat (80) begin
      wen = 1'($urandom_range(0, 1));
      waddr = 5'($urandom_range(0, 7));
      wdata = {$urandom, $urandom};
      wbyteen = 8'($urandom);
      rd_en = 4'($urandom);
      for (int p = 0; p < NRP; p++) raddr[p] = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    repeat (3) step();

    // Reset in the middle of a read stream
    rd_en = 4'hF; raddr[0] = 5'd1; raddr[1] = 5'd2; raddr[2] = 5'd3; raddr[3] = 5'd9;
    repeat (4) step();
    reset = 1'b1;
    vld_cnt = 0;
    step();
    reset = 1'b0;
    wen = 1'b1; waddr = 5'd9; wdata = 64'h1234; wbyteen = 8'hFF;
    repeat (32) step();
    chk("no_rvalid_through_init", 64'(vld_cnt), 64'd0);
    idle();
    clear_last();
    rd_en = 4'h1; raddr[0] = 5'd9;
    step();
    idle();
    repeat (3) step();
    for (int d = 0; d < 2; d++)
      chk($sformatf("post_reset_init_dut%0d", d), last_rd[d][0], INIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
